channel_select_sequencer: RTL and testbench

- Serialises a parallel channel-select word onto the two-wire GPIO control lines (sel_clk, sdata) that feed the 16-bit channel-select shift register.
- Two requesters share those lines: A is the host/GPIO path and B is the experiment sequencer. A round-robin arbiter picks one.
- Each granted word is shifted out MSB first at a programmable bit rate, followed by a one-cycle commit pulse.
- Sits between the control-plane requesters and gpio_ctrl[sel_clk] / gpio_ctrl[sdata].

---
 rtl/channel_select_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_channel_select_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_select_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : channel_select_sequencer                                  |
// | Two-requester round-robin arbiter that shifts the granted word     |
// | MSB first onto sel_clk/sdata, then pulses done for one cycle.      |
// | Option : define CHSEL_SHADOW_EN to build the shadow_select         |
// |          read-back register (otherwise shadow_select is 0).        |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module channel_select_sequencer #(
  parameter int WIDTH   = 16,
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data,
  output logic             sel_clk,
  output logic             sdata,
  output logic             busy,
  output logic             done,
  output logic             grant_id,
  output logic [WIDTH-1:0] shadow_select
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_low  = 2'd1;
  localparam logic [1:0] c_st_high = 2'd2;
  localparam logic [1:0] c_st_done = 2'd3;

  localparam int                 c_bit_w    = $clog2(WIDTH + 1);
  localparam logic [7:0]         c_div_last = 8'(CLK_DIV - 1);
  localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(WIDTH - 1);
  localparam logic [c_bit_w-1:0] c_bit_one  = c_bit_w'(1);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [7:0]         r_div;
  logic [c_bit_w-1:0] r_bit;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   w_shift_nxt;
  logic               r_ptr;
  logic               r_grant;
  logic               r_sclk;
  logic               r_sdata;
  logic               r_busy;
  logic               r_done;
  logic               w_idle;
  logic               w_a_rdy;
  logic               w_b_rdy;
  logic               w_hs;
  logic               w_div_end;
  logic               w_last_bit;
  logic               w_high_end;
  logic               w_sclk_nxt;
  logic               w_sdata_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;

  // Round-robin arbitration; r_ptr = 1 favours B. Ready only offered in IDLE.
  always_comb begin
    w_idle  = (r_state == c_st_idle);
    w_a_rdy = w_idle & a_valid & (~b_valid | ~r_ptr);
    w_b_rdy = w_idle & b_valid & (~a_valid |  r_ptr);
    w_hs    = w_a_rdy | w_b_rdy;
  end

  assign a_ready    = w_a_rdy;
  assign b_ready    = w_b_rdy;
  assign w_div_end  = (r_div == c_div_last);
  assign w_last_bit = (r_bit == c_bit_last);
  assign w_high_end = (r_state == c_st_high) & w_div_end;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= c_st_idle;
    else      r_state <= w_state_nxt;
  end

  // Next-state: each serial phase lasts CLK_DIV cycles, DONE lasts one
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (w_hs)      w_state_nxt = c_st_low;
      c_st_low:  if (w_div_end) w_state_nxt = c_st_high;
      c_st_high: if (w_div_end) w_state_nxt = w_last_bit ? c_st_done : c_st_low;
      c_st_done:                w_state_nxt = c_st_idle;
      default:                  w_state_nxt = c_st_idle;
    endcase
  end

  // Shift word: load winner on handshake, move to next bit when leaving HIGH
  always_comb begin
    w_shift_nxt = r_shift;
    if (w_hs)            w_shift_nxt = w_b_rdy ? b_data : a_data;
    else if (w_high_end) w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
  end

  // Output decode from the upcoming state so the pins come straight from flops
  always_comb begin
    w_sclk_nxt  = (w_state_nxt == c_st_high);
    w_busy_nxt  = (w_state_nxt != c_st_idle);
    w_done_nxt  = (w_state_nxt == c_st_done);
    w_sdata_nxt = 1'b0;
    case (w_state_nxt)
      c_st_low:  w_sdata_nxt = w_shift_nxt[WIDTH-1];
      c_st_high: w_sdata_nxt = r_sdata;
      default:   w_sdata_nxt = 1'b0;
    endcase
  end

  // Registered serial/status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk  <= 1'b0;
      r_sdata <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_sclk  <= w_sclk_nxt;
      r_sdata <= w_sdata_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Datapath: divider reloads on any state change and saturates at terminal count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_ptr   <= 1'b0;
      r_grant <= 1'b0;
    end else begin
      r_shift <= w_shift_nxt;
      if (w_state_nxt != r_state) r_div <= '0;
      else if (!w_div_end)        r_div <= r_div + 8'd1;
      if (w_hs) begin
        r_bit   <= '0;
        r_grant <= w_b_rdy;
        r_ptr   <= ~w_b_rdy;
      end else if (w_high_end) begin
        r_bit   <= r_bit + c_bit_one;
      end
    end
  end

  assign sel_clk  = r_sclk;
  assign sdata    = r_sdata;
  assign busy     = r_busy;
  assign done     = r_done;
  assign grant_id = r_grant;

`ifdef CHSEL_SHADOW_EN
  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] r_shadow;

  // Keep an intact copy of the word (the shift word is consumed) and commit it on entry to DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word   <= '0;
      r_shadow <= '0;
    end else begin
      if (w_hs)       r_word   <= w_shift_nxt;
      if (w_done_nxt) r_shadow <= r_word;
    end
  end

  assign shadow_select = r_shadow;
`else
  assign shadow_select = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_channel_select_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_channel_select_sequencer                               |
// | Bench for channel_select_sequencer (CLK_DIV=2 and CLK_DIV=1).      |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module tb_channel_select_sequencer;

  localparam int W   = 16;
  localparam int CD  = 2;
  localparam int LAT = 1 + 2 * CD * W;
`ifdef CHSEL_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         a_valid = 1'b0, b_valid = 1'b0;
  logic [W-1:0] a_data = '0, b_data = '0;
  logic         a_ready, b_ready, sel_clk, sdata, busy, done, grant_id;
  logic [W-1:0] shadow_select;

  logic         a1_valid = 1'b0, b1_valid = 1'b0;
  logic [W-1:0] a1_data = '0, b1_data = '0;
  logic         a1_ready, b1_ready, sel1, sdata1, busy1, done1, grant1;
  logic [W-1:0] shadow1;

  channel_select_sequencer #(.WIDTH(W), .CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .sel_clk(sel_clk), .sdata(sdata), .busy(busy), .done(done),
    .grant_id(grant_id), .shadow_select(shadow_select)
  );

  channel_select_sequencer #(.WIDTH(W), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst),
    .a_valid(a1_valid), .a_ready(a1_ready), .a_data(a1_data),
    .b_valid(b1_valid), .b_ready(b1_ready), .b_data(b1_data),
    .sel_clk(sel1), .sdata(sdata1), .busy(busy1), .done(done1),
    .grant_id(grant1), .shadow_select(shadow1)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [W-1:0] word;
    logic         g;
    int           t0;
  } exp_t;
  exp_t sb_q[$];

  // Reference model state
  bit           m_ptr = 1'b0;      // 1 = B is owed the next tie
  int           next_free = 0;     // first cycle a new handshake may happen
  int           last_t0 = 0;
  bit           a_pend = 1'b0, b_pend = 1'b0;
  logic [W-1:0] a_word = '0, b_word = '0;
  int           mode = 0;          // 0 none, 1 A always, 2 both always, 3 random

  task automatic step();
    bit   ea, eb;
    exp_t e;
    @(posedge clk); #1;
    a_valid = a_pend; a_data = a_word;
    b_valid = b_pend; b_data = b_word;
    @(negedge clk);
    ea = (cyc >= next_free) && a_pend && (!b_pend || !m_ptr);
    eb = (cyc >= next_free) && b_pend && (!a_pend ||  m_ptr);
    chk("a_ready", 32'(a_ready), 32'(ea));
    chk("b_ready", 32'(b_ready), 32'(eb));
    chk("busy", 32'(busy), 32'((cyc > last_t0) && (cyc < next_free)));
    if (ea || eb) begin
      e.word = eb ? b_word : a_word;
      e.g    = eb;
      e.t0   = cyc;
      sb_q.push_back(e);
      m_ptr     = !eb;
      last_t0   = cyc;
      next_free = cyc + LAT + 1;
      if (eb) b_pend = 1'b0; else a_pend = 1'b0;
    end
    if (!a_pend) a_word = 16'($urandom);
    if (!b_pend) b_word = 16'($urandom);
    case (mode)
      1: a_pend = 1'b1;
      2: begin a_pend = 1'b1; b_pend = 1'b1; end
      3: begin
        if (!a_pend) a_pend = ($urandom_range(3) == 0);
        else if ($urandom_range(15) == 0) a_pend = 1'b0;
        if (!b_pend) b_pend = ($urandom_range(3) == 0);
        else if ($urandom_range(15) == 0) b_pend = 1'b0;
      end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1'b0;
    a_pend = 1'b0; b_pend = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    #1;
    chk("rst_sel_clk", 32'(sel_clk), 32'd0);
    chk("rst_sdata", 32'(sdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_shadow", 32'(shadow_select), 32'd0);
    sb_q.delete();
    m_ptr = 1'b0; next_free = 0; last_t0 = 0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
  endtask

  // Monitor: collects serial bits at sel_clk rises and retires a word on done
  logic [W-1:0] mon_col = '0;
  int           mon_n = 0;
  logic         mon_prev = 1'b0;
  logic         mon_hold = 1'b0;
  exp_t         mon_e;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      mon_col = '0; mon_n = 0; mon_prev = 1'b0;
    end else begin
      if (sel_clk && !mon_prev) begin
        mon_col  = {mon_col[W-2:0], sdata};
        mon_n++;
        mon_hold = sdata;
      end else if (sel_clk) begin
        chk("sdata_stable_high", 32'(sdata), 32'(mon_hold));
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          mon_e = sb_q.pop_front();
          chk("serial_word", 32'(mon_col), 32'(mon_e.word));
          chk("bit_count", 32'(mon_n), 32'(W));
          chk("done_cycle", 32'(cyc), 32'(mon_e.t0 + LAT));
          chk("grant_id", 32'(grant_id), 32'(mon_e.g));
          chk("done_busy", 32'(busy), 32'd1);
          chk("done_pins", 32'({sel_clk, sdata}), 32'd0);
          chk("shadow_at_done", 32'(shadow_select), SHADOW ? 32'(mon_e.word) : 32'd0);
        end
        mon_col = '0; mon_n = 0;
      end
      mon_prev = sel_clk;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int t1;
    #1 rst = 1'b0;
    #2;
    chk("init_sel_clk", 32'(sel_clk), 32'd0);
    chk("init_sdata", 32'(sdata), 32'd0);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_done", 32'(done), 32'd0);
    chk("init_grant_id", 32'(grant_id), 32'd0);
    chk("init_shadow", 32'(shadow_select), 32'd0);
    chk("init_ready", 32'({a_ready, b_ready}), 32'd0);
    #10 rst = 1'b1;

    // Single A word
    a_pend = 1'b1; a_word = 16'hA5C3;
    repeat (70) step();
    chk("shadow_A5C3", 32'(shadow_select), SHADOW ? 32'h0000A5C3 : 32'd0);

    // Simultaneous request right after reset: A first, then B
    do_reset();
    a_pend = 1'b1; a_word = 16'h0001;
    b_pend = 1'b1; b_word = 16'h8000;
    repeat (140) step();
    chk("shadow_8000", 32'(shadow_select), SHADOW ? 32'h00008000 : 32'd0);

    // Both requesters continuously valid for four words
    mode = 2;
    repeat (4 * (LAT + 1)) step();
    mode = 0; a_pend = 1'b0; b_pend = 1'b0;
    repeat (70) step();

    // Only A continuously valid
    mode = 1;
    repeat (3 * (LAT + 1)) step();
    mode = 0; a_pend = 1'b0;
    repeat (70) step();

    // Reset during bit 7 of a B word, then a fresh word
    do_reset();
    b_pend = 1'b1; b_word = 16'($urandom);
    repeat (31) step();
    do_reset();
    a_pend = 1'b1; a_word = 16'h5A3C;
    repeat (70) step();

    // Random traffic
    mode = 3;
    repeat (1500) step();
    mode = 0; a_pend = 1'b0; b_pend = 1'b0;
    repeat (70) step();
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    // CLK_DIV = 1 instance, B word of all ones
    t1 = -1;
    @(posedge clk); #1;
    b1_valid = 1'b1; b1_data = 16'hFFFF;
    for (int k = 0; k < 10 && t1 < 0; k++) begin
      @(negedge clk);
      if (b1_ready) t1 = cyc;
    end
    if (t1 < 0) begin
      n_checks++; n_fail++;
      $display("FAIL div1_ready_timeout: actual=0 required=1");
    end else begin
      @(posedge clk); #1;
      b1_valid = 1'b0; b1_data = '0;
      for (int k = 1; k <= 33; k++) begin
        @(negedge clk);
        if (k <= 32) begin
          chk("div1_sel_clk", 32'(sel1), 32'(k % 2 == 0));
          chk("div1_sdata", 32'(sdata1), 32'd1);
        end
        chk("div1_done", 32'(done1), 32'(k == 33));
        chk("div1_busy", 32'(busy1), 32'd1);
        chk("div1_a_ready", 32'(a1_ready), 32'd0);
      end
      chk("div1_grant_id", 32'(grant1), 32'd1);
      chk("div1_shadow", 32'(shadow1), SHADOW ? 32'h0000FFFF : 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
